// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU): quotient to lo_o, remainder to hi_o.
// Define DIV_EARLY_ZERO_EN to finish a divide-by-zero one cycle after load.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividendo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: load_i is taken only in S_IDLE; busy_o is high from the accepting
  // edge until results are written; done_o pulses for the cycle hi_o/lo_o change.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, trial;

  assign neg_a = is_signed_i & dividendo_i[WIDTH-1];
  assign neg_b = is_signed_i & divisor_i[WIDTH-1];
  assign mag_a = neg_a ? -dividendo_i : dividendo_i;
  assign mag_b = neg_b ? -divisor_i : divisor_i;

  // 33-bit trial subtraction; bit WIDTH set means the partial remainder was too small.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          rem_d   = '0;
          cnt_d   = '0;
          quo_d   = mag_a;
          dvs_d   = mag_b;
          raw_d   = dividendo_i;
          q_neg_d = neg_a ^ neg_b;
          r_neg_d = neg_a;
          zero_d  = (divisor_i == '0);
          busy_d  = 1'b1;
          state_d = S_CALC;
`ifdef DIV_EARLY_ZERO_EN
          if (divisor_i == '0) state_d = S_FIX;
`else
`endif
        end
      end
      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // Truncating signed division: remainder follows the dividend's sign.
        lo_d    = zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        hi_d    = zero_q ? raw_q : (r_neg_q ? -rem_q : rem_q);
        dz_d    = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign div_zero_o  = dz_q;
  assign dbg_state_o = state_q;

endmodule
